// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL_CORE LMMI reconfiguration master:
// FSM state encoding, completion status codes and a counter sizing helper.
package pll_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_REQ    = 3'd1,
    RD_WAIT   = 3'd2,
    WR_REQ    = 3'd3,
    PLL_RST   = 3'd4,
    LOCK_WAIT = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_LOCK_TO = 2'b01;
  localparam logic [1:0] ST_RD_TO   = 2'b10;

  // Width of a counter that runs 0 .. limit-1; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability chain: first flop may go metastable, second settles it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lmmi_reconfig.sv
// LMMI dynamic-reconfiguration master for PLL_CORE. Each host command is a
// masked register update done as read-modify-write (or a plain write when the
// mask covers the whole byte). A command flagged last is followed by a PLL
// reset pulse and a lock wait with timeout; every command ends in one
// done_valid pulse carrying its status.
module pll_lmmi_reconfig
  import pll_cfg_pkg::*;
#(
  parameter int OFFSET_W     = 7,
  parameter int DATA_W       = 8,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int RD_TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OFFSET_W-1:0] cmd_offset,
  input  logic [DATA_W-1:0]   cmd_mask,
  input  logic [DATA_W-1:0]   cmd_value,
  input  logic                cmd_last,
  output logic                done_valid,
  output logic [1:0]          done_status,
  output logic                lmmi_request,
  output logic                lmmi_wr_rdn,
  output logic [OFFSET_W-1:0] lmmi_offset,
  output logic [DATA_W-1:0]   lmmi_wdata,
  input  logic [DATA_W-1:0]   lmmi_rdata,
  input  logic                lmmi_rdata_valid,
  input  logic                lmmi_ready,
  output logic                pll_rstn,
  input  logic                pll_lock
);

  localparam int RD_CW   = cnt_width(RD_TIMEOUT);
  localparam int RST_CW  = cnt_width(RST_CYCLES);
  localparam int LOCK_CW = cnt_width(LOCK_TIMEOUT);

  localparam logic [RD_CW-1:0]   RD_LAST   = RD_CW'(RD_TIMEOUT - 1);
  localparam logic [RST_CW-1:0]  RST_LAST  = RST_CW'(RST_CYCLES - 1);
  localparam logic [LOCK_CW-1:0] LOCK_LAST = LOCK_CW'(LOCK_TIMEOUT - 1);

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_done_valid;
  logic [1:0]          r_done_status;
  logic                r_lmmi_request;
  logic                r_lmmi_wr_rdn;
  logic [OFFSET_W-1:0] r_lmmi_offset;
  logic [DATA_W-1:0]   r_lmmi_wdata;
  logic                r_pll_rstn;
  logic [RD_CW-1:0]    r_rd_cnt;
  logic [RST_CW-1:0]   r_rst_cnt;
  logic [LOCK_CW-1:0]  r_lock_cnt;
  logic                r_lock_run;
  logic [DATA_W-1:0]   r_mask;
  logic [DATA_W-1:0]   r_value;
  logic                r_last;

  logic                w_accept;
  logic                w_lock_s;

  // Counters stop at their terminal value instead of wrapping.
  function automatic logic [RD_CW-1:0] sat_inc_rd(input logic [RD_CW-1:0] v);
    return (v == RD_LAST) ? v : v + RD_CW'(1);
  endfunction

  function automatic logic [RST_CW-1:0] sat_inc_rst(input logic [RST_CW-1:0] v);
    return (v == RST_LAST) ? v : v + RST_CW'(1);
  endfunction

  function automatic logic [LOCK_CW-1:0] sat_inc_lock(input logic [LOCK_CW-1:0] v);
    return (v == LOCK_LAST) ? v : v + LOCK_CW'(1);
  endfunction

  // Keep unmasked bits from the target, take masked bits from the command.
  function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] rdata,
                                                  input logic [DATA_W-1:0] mask,
                                                  input logic [DATA_W-1:0] value);
    return (rdata & ~mask) | (value & mask);
  endfunction

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_accept = (r_state == IDLE) && cmd_valid && r_cmd_ready;

  // Capture the command fields used later by the merge and the last-flag branch.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mask  <= cmd_mask;
      r_value <= cmd_value;
      r_last  <= cmd_last;
    end
  end

  // Command sequencer: read, merge, write, optional PLL reset and lock wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cmd_ready    <= 1'b0;
      r_done_valid   <= 1'b0;
      r_done_status  <= ST_OK;
      r_lmmi_request <= 1'b0;
      r_lmmi_wr_rdn  <= 1'b0;
      r_lmmi_offset  <= '0;
      r_lmmi_wdata   <= '0;
      r_pll_rstn     <= 1'b1;
      r_rd_cnt       <= '0;
      r_rst_cnt      <= '0;
      r_lock_cnt     <= '0;
      r_lock_run     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready    <= 1'b0;
            r_lmmi_request <= 1'b1;
            r_lmmi_offset  <= cmd_offset;
            if (&cmd_mask) begin
              r_lmmi_wr_rdn <= 1'b1;
              r_lmmi_wdata  <= cmd_value;
              r_state       <= WR_REQ;
            end else begin
              r_lmmi_wr_rdn <= 1'b0;
              r_state       <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (lmmi_ready) begin
            r_lmmi_request <= 1'b0;
            r_rd_cnt       <= '0;
            r_state        <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lmmi_rdata_valid) begin
            r_lmmi_request <= 1'b1;
            r_lmmi_wr_rdn  <= 1'b1;
            r_lmmi_wdata   <= rmw_merge(lmmi_rdata, r_mask, r_value);
            r_state        <= WR_REQ;
          end else if (r_rd_cnt == RD_LAST) begin
            r_done_status <= ST_RD_TO;
            r_done_valid  <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_rd_cnt <= sat_inc_rd(r_rd_cnt);
          end
        end
        WR_REQ: begin
          if (lmmi_ready) begin
            r_lmmi_request <= 1'b0;
            if (r_last) begin
              r_pll_rstn <= 1'b0;
              r_rst_cnt  <= '0;
              r_state    <= PLL_RST;
            end else begin
              r_done_status <= ST_OK;
              r_done_valid  <= 1'b1;
              r_state       <= DONE;
            end
          end
        end
        PLL_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            r_pll_rstn <= 1'b1;
            r_lock_cnt <= '0;
            r_lock_run <= 1'b0;
            r_state    <= LOCK_WAIT;
          end else begin
            r_rst_cnt <= sat_inc_rst(r_rst_cnt);
          end
        end
        LOCK_WAIT: begin
          // Lock is believed only after two consecutive synchronized highs.
          r_lock_run <= w_lock_s;
          if (w_lock_s && r_lock_run) begin
            r_done_status <= ST_OK;
            r_done_valid  <= 1'b1;
            r_state       <= DONE;
          end else if (r_lock_cnt == LOCK_LAST) begin
            r_done_status <= ST_LOCK_TO;
            r_done_valid  <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_lock_cnt <= sat_inc_lock(r_lock_cnt);
          end
        end
        DONE: begin
          r_done_valid <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign done_valid   = r_done_valid;
  assign done_status  = r_done_status;
  assign lmmi_request = r_lmmi_request;
  assign lmmi_wr_rdn  = r_lmmi_wr_rdn;
  assign lmmi_offset  = r_lmmi_offset;
  assign lmmi_wdata   = r_lmmi_wdata;
  assign pll_rstn     = r_pll_rstn;

endmodule
